// File: rtl/vector_loader.sv
// Element-pair vector loader: collects up to N (a,b) pairs into packed
// vectors (element 0 at the MSBs) and holds them until downstream consumes.
module vector_loader #(
   parameter  int N          = 2,
   parameter  int DATA_WIDTH = 32,
   localparam int CW         = $clog2(N + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_a,
   input  logic [DATA_WIDTH-1:0]     in_b,
   input  logic                      in_last,
   output logic [N*DATA_WIDTH-1:0]   out_a,
   output logic [N*DATA_WIDTH-1:0]   out_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CW-1:0]             out_count
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic [N*DATA_WIDTH-1:0] a_q, a_d;
   logic [N*DATA_WIDTH-1:0] b_q, b_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;

   logic xfer_s;
   logic last_s;
   logic consume_s;

   assign xfer_s    = (state_q == FILL) && in_valid;
   assign last_s    = in_last || (count_q == CW'(N - 1));
   assign consume_s = (state_q == HOLD) && out_ready;

   // Next-state: clear beats consume beats transfer; the slot index is the
   // running transfer count, so unwritten slots stay at their cleared zero.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      a_d         = a_q;
      b_d         = b_q;
      if (clear || consume_s) begin
         state_d = FILL;
         count_d = '0;
         a_d     = '0;
         b_d     = '0;
      end else if (xfer_s) begin
         for (int i = 0; i < N; i++) begin
            if (count_q == CW'(i)) begin
               a_d[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = in_a;
               b_d[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = in_b;
            end else begin
               a_d[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = a_q[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
               b_d[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = b_q[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         count_d = count_q + CW'(1);
         if (last_s) begin
            state_d = HOLD;
         end else begin
            state_d = FILL;
         end
      end else begin
         state_d = state_q;
      end
      in_ready_d  = (state_d == FILL);
      out_valid_d = (state_d == HOLD);
   end

   // State, slot and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         count_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         a_q         <= a_d;
         b_q         <= b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_a     = a_q;
   assign out_b     = b_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_vector_loader.sv
// Directed self-checking bench for vector_loader with N=4, DATA_WIDTH=16.
module tb_vector_loader;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = $clog2(N + 1);

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_a;
   logic [DW-1:0]     in_b;
   logic              in_last;
   logic [N*DW-1:0]   out_a;
   logic [N*DW-1:0]   out_b;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     out_count;

   int checks   = 0;
   int failures = 0;

   vector_loader #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_last = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_a",     out_a, 64'd0);
      chk("rst_out_count", {61'd0, out_count}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);

      // Full vector
      out_ready = 1'b1;
      send(16'd1, 16'd5, 1'b0);
      send(16'd2, 16'd6, 1'b0);
      send(16'd3, 16'd7, 1'b0);
      chk("full_not_yet_valid", {63'd0, out_valid}, 64'd0);
      send(16'd4, 16'd8, 1'b0);
      chk("full_out_valid", {63'd0, out_valid}, 64'd1);
      chk("full_in_ready",  {63'd0, in_ready}, 64'd0);
      chk("full_out_a",     out_a, 64'h0001_0002_0003_0004);
      chk("full_out_b",     out_b, 64'h0005_0006_0007_0008);
      chk("full_out_count", {61'd0, out_count}, 64'd4);
      idle();
      tick();
      chk("full_consumed_ready", {63'd0, in_ready}, 64'd1);
      chk("full_consumed_valid", {63'd0, out_valid}, 64'd0);
      chk("full_consumed_zero",  out_a, 64'd0);

      // Short vector with in_last on the second pair
      send(16'd9,  16'd1, 1'b0);
      send(16'd10, 16'd1, 1'b1);
      chk("short_out_valid", {63'd0, out_valid}, 64'd1);
      chk("short_out_a",     out_a, 64'h0009_000A_0000_0000);
      chk("short_out_b",     out_b, 64'h0001_0001_0000_0000);
      chk("short_out_count", {61'd0, out_count}, 64'd2);
      idle();
      tick();

      // Backpressure
      out_ready = 1'b0;
      send(16'd11, 16'd21, 1'b0);
      send(16'd12, 16'd22, 1'b0);
      send(16'd13, 16'd23, 1'b0);
      send(16'd14, 16'd24, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(16'hAAAA, 16'hBBBB, 1'b0);
         chk("bp_in_ready",  {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_out_a",     out_a, 64'h000B_000C_000D_000E);
         chk("bp_out_b",     out_b, 64'h0015_0016_0017_0018);
      end
      out_ready = 1'b1;
      in_a = 16'h0055; in_b = 16'h0066; in_last = 1'b1;
      tick();
      chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
      chk("bp_release_zero",  out_a, 64'd0);
      tick();
      chk("bp_next_a",     out_a, 64'h0055_0000_0000_0000);
      chk("bp_next_b",     out_b, 64'h0066_0000_0000_0000);
      chk("bp_next_count", {61'd0, out_count}, 64'd1);
      idle();
      tick();

      // Clear mid-fill, colliding with a transfer
      out_ready = 1'b0;
      send(16'd3, 16'd3, 1'b0);
      send(16'd3, 16'd3, 1'b0);
      send(16'd3, 16'd3, 1'b0);
      clear = 1'b1;
      send(16'h0099, 16'h0099, 1'b0);
      clear = 1'b0;
      chk("clr_count", {61'd0, out_count}, 64'd0);
      chk("clr_out_a", out_a, 64'd0);
      chk("clr_ready", {63'd0, in_ready}, 64'd1);
      send(16'd7, 16'd1, 1'b0);
      send(16'd7, 16'd2, 1'b0);
      send(16'd7, 16'd3, 1'b0);
      send(16'd7, 16'd4, 1'b1);
      chk("clr_full_a",     out_a, 64'h0007_0007_0007_0007);
      chk("clr_full_b",     out_b, 64'h0001_0002_0003_0004);
      chk("clr_full_count", {61'd0, out_count}, 64'd4);
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_hold_valid", {63'd0, out_valid}, 64'd0);
      chk("clr_hold_a",     out_a, 64'd0);

      // Asynchronous reset while holding
      send(16'd1, 16'd5, 1'b0);
      send(16'd2, 16'd6, 1'b0);
      send(16'd3, 16'd7, 1'b0);
      send(16'd4, 16'd8, 1'b0);
      idle();
      chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_out_a", out_a, 64'd0);
      chk("ar_count", {61'd0, out_count}, 64'd0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("ar_post_ready", {63'd0, in_ready}, 64'd1);
      chk("ar_post_valid", {63'd0, out_valid}, 64'd0);

      // Gapped input; in_last is raised on idle cycles and must be ignored
      for (int i = 0; i < N; i++) begin
         send(16'(i + 1), 16'(i + 5), 1'b0);
         in_valid = 1'b0;
         in_a     = 16'hDEAD;
         in_b     = 16'hBEEF;
         in_last  = 1'b1;
         tick();
         chk("gap_count", {61'd0, out_count}, 64'(i + 1));
      end
      idle();
      chk("gap_valid", {63'd0, out_valid}, 64'd1);
      chk("gap_out_a", out_a, 64'h0001_0002_0003_0004);
      chk("gap_out_b", out_b, 64'h0005_0006_0007_0008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
